// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single synchronous video RAM port between the
// text-mode scanout engine (absolute priority, zero added latency) and the
// CPU bus. CPU writes are posted through a one-entry write buffer, and CPU
// reads fit into the cycles where scanout does not need the port.
//
// CPU handshake: cpu_req is a level request. cpu_we, cpu_address and
// cpu_wdata stay stable while cpu_req=1. The arbiter completes the access
// with a single-cycle cpu_ack pulse; a read's data is valid on cpu_rdata
// during that pulse. After the ack cycle the CPU either drops cpu_req or
// presents its next request. cpu_req is not looked at while the ack is
// being shown.
module vram_arbiter #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clock_25,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_address,
  output logic [DW-1:0] vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          wbuf_busy,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
);

  // IDLE: waiting for a CPU request. RD_DATA: the RAM holds the CPU read
  // address and returns data this cycle. HOLD: the ack pulse is visible.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_DATA = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_wbuf_valid;
  logic [AW-1:0] r_wbuf_addr;
  logic [DW-1:0] r_wbuf_data;
  logic          r_cpu_ack;
  logic [DW-1:0] r_cpu_rdata;

  logic          w_drain;
  logic          w_rd_issue;
  logic          w_wr_accept;
  logic          w_ack_nxt;
  logic          w_rdata_load;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_address;

  // Port events. A read needs an empty buffer, so it can never overtake a
  // posted write to the same address and never coincides with a drain.
  // Accepting a write only touches the buffer, not the RAM port, so it
  // ignores vid_req.
  always_comb begin
    w_drain     = 1'b0;
    w_rd_issue  = 1'b0;
    w_wr_accept = 1'b0;
    w_drain     = !vid_req && r_wbuf_valid;
    w_rd_issue  = !vid_req && !r_wbuf_valid && (r_state == ST_IDLE) &&
                  cpu_req && !cpu_we;
    w_wr_accept = (r_state == ST_IDLE) && cpu_req && cpu_we && !r_wbuf_valid;
  end

  // RAM port mux: scanout first, then the buffer drain, otherwise the CPU
  // address (a real read when issuing, a harmless read otherwise).
  always_comb begin
    w_mem_address = cpu_address;
    w_mem_we      = 1'b0;
    if (vid_req) begin
      w_mem_address = vid_address;
    end else if (r_wbuf_valid) begin
      w_mem_address = r_wbuf_addr;
      w_mem_we      = 1'b1;
    end
  end

  // Next state and ack/read-data control. RD_DATA advances unconditionally
  // because the RAM already latched the CPU address on the previous edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_ack_nxt    = 1'b0;
    w_rdata_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_issue) begin
          w_state_nxt = ST_RD_DATA;
        end else if (w_wr_accept) begin
          w_state_nxt = ST_HOLD;
          w_ack_nxt   = 1'b1;
        end
      end
      ST_RD_DATA: begin
        w_state_nxt  = ST_HOLD;
        w_ack_nxt    = 1'b1;
        w_rdata_load = 1'b1;
      end
      ST_HOLD: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ack pulse and CPU read data; read data holds until the next read.
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_cpu_ack <= w_ack_nxt;
      if (w_rdata_load) begin
        r_cpu_rdata <= mem_rdata;
      end
    end
  end

  // One-entry posted write buffer; reset discards a pending write.
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_wbuf_valid <= 1'b0;
      r_wbuf_addr  <= '0;
      r_wbuf_data  <= '0;
    end else if (w_wr_accept) begin
      r_wbuf_valid <= 1'b1;
      r_wbuf_addr  <= cpu_address;
      r_wbuf_data  <= cpu_wdata;
    end else if (w_drain) begin
      r_wbuf_valid <= 1'b0;
    end
  end

  assign mem_address = w_mem_address;
  assign mem_wdata   = r_wbuf_data;
  assign mem_we      = w_mem_we && reset_n;
  assign vid_data    = mem_rdata;
  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_ack     = r_cpu_ack;
  assign wbuf_busy   = r_wbuf_valid;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed cycle-exact scenarios plus a randomized
// scanout/CPU interleave, checked against a simple memory model.
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;

  logic          clock_25;
  logic          reset_n;
  logic          vid_req;
  logic [AW-1:0] vid_address;
  logic [DW-1:0] vid_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          wbuf_busy;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_state;

  // Bench RAM (synchronous, 1-cycle read latency) with a side preload port.
  logic [DW-1:0] ram [8192] = '{default: 8'h00};
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  // Reference: CPU-visible memory in program order, and the pending writes
  // in the order they were acknowledged.
  logic [DW-1:0] exp_mem [8192] = '{default: 8'h00};
  logic [AW+DW-1:0] exp_q [$];

  int n_tests;
  int n_fail;
  bit cad_done;

  vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock_25    (clock_25),
    .reset_n     (reset_n),
    .vid_req     (vid_req),
    .vid_address (vid_address),
    .vid_data    (vid_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .wbuf_busy   (wbuf_busy),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial begin
    clock_25 = 1'b0;
    forever #20 clock_25 = ~clock_25;
  end

  // RAM model
  always @(posedge clock_25) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_address] <= mem_wdata;
    mem_rdata <= ram[mem_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock_25);
    #1;
  endtask

  task automatic neg();
    @(negedge clock_25);
  endtask

  // Per-cycle protocol monitor: scanout ownership, scanout data, buffer
  // status and drain order.
  task automatic monitor_loop();
    bit            vpend = 0;
    logic [DW-1:0] vexp = '0;
    logic [AW+DW-1:0] w;
    forever begin
      neg();
      if (!reset_n) begin
        check("rst_mem_we", mem_we, 0);
        exp_q.delete();
        vpend = 0;
      end else begin
        if (vpend) check("vid_data", vid_data, vexp);
        vpend = 0;
        if (vid_req) begin
          check("vid_addr", mem_address, vid_address);
          check("vid_we", mem_we, 0);
          vpend = 1;
          vexp  = ram[vid_address];
        end
        if (cpu_ack && cpu_req && cpu_we) exp_q.push_back({cpu_address, cpu_wdata});
        check("wbuf_busy", wbuf_busy, (exp_q.size() != 0));
        if (mem_we) begin
          if (exp_q.size() == 0) begin
            check("drain_unexpected", mem_we, 0);
          end else begin
            w = exp_q.pop_front();
            check("drain_order", {mem_address, mem_wdata}, w);
          end
        end
      end
    end
  endtask

  task automatic test_idle_read();
    pre_we = 1; pre_addr = 13'h0123; pre_data = 8'h5A;
    exp_mem[13'h0123] = 8'h5A;
    tick();
    pre_we = 0;
    cpu_req = 1; cpu_we = 0; cpu_address = 13'h0123;
    neg();
    check("rd_c0_addr", mem_address, 13'h0123);
    check("rd_c0_we", mem_we, 0);
    check("rd_c0_ack", cpu_ack, 0);
    tick(); neg();
    check("rd_c1_ack", cpu_ack, 0);
    tick(); neg();
    check("rd_c2_ack", cpu_ack, 1);
    check("rd_c2_data", cpu_rdata, 8'h5A);
    tick();
    cpu_req = 0;
    neg();
    check("rd_c3_ack", cpu_ack, 0);
    check("rd_c3_hold", cpu_rdata, 8'h5A);
    tick();
  endtask

  task automatic test_posted_write();
    cpu_req = 1; cpu_we = 1; cpu_address = 13'h0001; cpu_wdata = 8'h1F;
    exp_mem[13'h0001] = 8'h1F;
    vid_req = 1; vid_address = 13'h0800;
    neg();
    check("pw_c0_ack", cpu_ack, 0);
    check("pw_c0_we", mem_we, 0);
    tick();
    vid_address = 13'h0801;
    neg();
    check("pw_c1_ack", cpu_ack, 1);
    check("pw_c1_busy", wbuf_busy, 1);
    check("pw_c1_we", mem_we, 0);
    tick();
    cpu_req = 0; cpu_we = 0;
    vid_address = 13'h0802;
    neg();
    check("pw_c2_ack", cpu_ack, 0);
    check("pw_c2_busy", wbuf_busy, 1);
    check("pw_c2_we", mem_we, 0);
    tick();
    vid_req = 0;
    neg();
    check("pw_c3_we", mem_we, 1);
    check("pw_c3_addr", mem_address, 13'h0001);
    check("pw_c3_wdata", mem_wdata, 8'h1F);
    tick(); neg();
    check("pw_c4_busy", wbuf_busy, 0);
    check("pw_c4_we", mem_we, 0);
    tick();
  endtask

  task automatic test_raw();
    cpu_req = 1; cpu_we = 1; cpu_address = 13'h1010; cpu_wdata = 8'hA7;
    exp_mem[13'h1010] = 8'hA7;
    vid_req = 1; vid_address = 13'h0900;
    neg();
    check("raw_c0_ack", cpu_ack, 0);
    tick(); neg();
    check("raw_c1_ack", cpu_ack, 1);
    tick();
    cpu_we = 0; vid_req = 0;
    neg();
    check("raw_c2_drain", mem_we, 1);
    check("raw_c2_addr", mem_address, 13'h1010);
    check("raw_c2_ack", cpu_ack, 0);
    tick(); neg();
    check("raw_c3_issue_addr", mem_address, 13'h1010);
    check("raw_c3_we", mem_we, 0);
    check("raw_c3_state", dbg_state, S_IDLE);
    tick(); neg();
    check("raw_c4_state", dbg_state, S_RD);
    check("raw_c4_ack", cpu_ack, 0);
    tick(); neg();
    check("raw_c5_ack", cpu_ack, 1);
    check("raw_c5_data", cpu_rdata, 8'hA7);
    tick();
    cpu_req = 0;
    tick();
  endtask

  task automatic test_b2b();
    cpu_req = 1; cpu_we = 1; cpu_address = 13'h0200; cpu_wdata = 8'h11;
    vid_req = 1; vid_address = 13'h0A00;
    neg();
    check("b2b_c0_ack", cpu_ack, 0);
    tick(); neg();
    check("b2b_c1_ack", cpu_ack, 1);
    tick();
    cpu_wdata = 8'h22;
    exp_mem[13'h0200] = 8'h22;
    neg();
    check("b2b_c2_ack", cpu_ack, 0);
    check("b2b_c2_we", mem_we, 0);
    tick();
    vid_req = 0;
    neg();
    check("b2b_c3_drain1", mem_we, 1);
    check("b2b_c3_data1", mem_wdata, 8'h11);
    check("b2b_c3_ack", cpu_ack, 0);
    tick(); neg();
    check("b2b_c4_ack", cpu_ack, 0);
    check("b2b_c4_we", mem_we, 0);
    tick(); neg();
    check("b2b_c5_ack", cpu_ack, 1);
    check("b2b_c5_drain2", mem_we, 1);
    check("b2b_c5_data2", mem_wdata, 8'h22);
    tick();
    cpu_req = 0; cpu_we = 0;
    neg();
    check("b2b_c6_busy", wbuf_busy, 0);
    tick();
  endtask

  task automatic test_reset_mid_read();
    cpu_req = 1; cpu_we = 0; cpu_address = 13'h0123;
    tick(); neg();
    check("rst_in_rd", dbg_state, S_RD);
    #5;
    reset_n = 0;
    #1;
    check("rst_async_ack", cpu_ack, 0);
    check("rst_async_state", dbg_state, S_IDLE);
    check("rst_async_we", mem_we, 0);
    check("rst_async_rdata", cpu_rdata, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); neg();
      check("rst_hold_ack", cpu_ack, 0);
      check("rst_hold_state", dbg_state, S_IDLE);
    end
    tick();
    cpu_req = 0;
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      neg();
      check("rst_post_ack", cpu_ack, 0);
      tick();
    end
  endtask

  task automatic cpu_op(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic [DW-1:0] exp = '0;
    int lat = 0;
    bit got = 0;
    if (we) exp_mem[addr] = data;
    else exp = exp_mem[addr];
    cpu_req = 1; cpu_we = we; cpu_address = addr; cpu_wdata = data;
    while (!got && lat < 40) begin
      neg();
      if (cpu_ack) begin
        got = 1;
        if (!we) check("cad_rdata", cpu_rdata, exp);
      end else begin
        lat++;
      end
      tick();
    end
    check("cad_ack_seen", got, 1);
    if (got && !we) check("cad_rd_lat_min", (lat >= 2), 1);
    if (got && we) check("cad_wr_lat_min", (lat >= 1), 1);
    cpu_req = 0;
  endtask

  task automatic test_cadence();
    cad_done = 0;
    fork
      begin
        int ph = 0;
        int guard = 0;
        logic [AW-1:0] sa = 13'h0038;
        while (!cad_done && guard < 6000) begin
          vid_req = (ph < 3);
          vid_address = sa;
          if (ph < 3) sa = sa + 1'b1;
          ph = (ph + 1) % 8;
          guard++;
          tick();
        end
        vid_req = 0;
      end
      begin
        for (int k = 0; k < 20; k++) begin
          logic [AW-1:0] a;
          a = ($urandom_range(0, 1) == 1) ? 13'h1F00 : 13'h0040;
          a = a + AW'($urandom_range(0, 7));
          cpu_op(1'($urandom_range(0, 1)), a, DW'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 2)) tick();
        end
        cad_done = 1;
      end
    join
    vid_req = 0;
    repeat (4) tick();
  endtask

  task automatic final_ram_check();
    logic [AW-1:0] list [$];
    list = '{13'h0001, 13'h0123, 13'h1010, 13'h0200};
    for (int i = 0; i < 8; i++) begin
      list.push_back(AW'(13'h0040 + i));
      list.push_back(AW'(13'h1F00 + i));
    end
    foreach (list[i]) check("ram_final", ram[list[i]], exp_mem[list[i]]);
    neg();
    check("final_wbuf_idle", wbuf_busy, 0);
    tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 0; vid_req = 0; vid_address = '0;
    cpu_req = 0; cpu_we = 0; cpu_address = '0; cpu_wdata = '0;
    pre_we = 0; pre_addr = '0; pre_data = '0;
    fork
      monitor_loop();
    join_none
    repeat (3) tick();
    neg();
    check("reset_ack", cpu_ack, 0);
    check("reset_rdata", cpu_rdata, 0);
    check("reset_busy", wbuf_busy, 0);
    check("reset_we", mem_we, 0);
    check("reset_state", dbg_state, S_IDLE);
    tick();
    reset_n = 1;
    tick();
    test_idle_read();
    test_posted_write();
    test_raw();
    test_b2b();
    test_reset_mid_read();
    test_cadence();
    final_ram_check();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
